// File: rtl/axis_defs_pkg.sv
// Shared constants for the 8-bit AXI-Stream byte FIFO.
// Word layout: {last, data[7:0]}.
package axis_defs_pkg;
   localparam int AXIS_DATA_W    = 8;
   localparam int AXIS_WORD_W    = 9;
   localparam int AXIS_DEPTH_DEF = 16;
   localparam int AXIS_LAST_BIT  = 8;
endpackage

// File: rtl/axis_fifo_ram.sv
// DEPTH x 9 simple dual-port RAM, synchronous write, async read.
// Ports: clk, we/waddr/wdata write side, raddr/rdata read side.
module axis_fifo_ram
   import axis_defs_pkg::*;
#(
   parameter int DEPTH = AXIS_DEPTH_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [AW-1:0]          waddr,
   input  logic [AXIS_WORD_W-1:0] wdata,
   input  logic [AW-1:0]          raddr,
   output logic [AXIS_WORD_W-1:0] rdata
);

   logic [AXIS_WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/axis_byte_fifo.sv
// Byte-wide AXI-Stream FIFO with FWFT output, frame count, overflow flag.
// Ports: clk, reset (async, active-low); s_* upstream slave side;
// m_* downstream master side; level, frames, overflow status.
// Define AXIS_FIFO_PKT_MODE_EN for packet (store-and-forward) mode.
module axis_byte_fifo
   import axis_defs_pkg::*;
#(
   parameter  int DEPTH = AXIS_DEPTH_DEF,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [AXIS_DATA_W-1:0] s_data,
   input  logic                   s_valid,
   input  logic                   s_last,
   output logic                   s_ready,
   output logic [AXIS_DATA_W-1:0] m_data,
   output logic                   m_valid,
   output logic                   m_last,
   input  logic                   m_ready,
   output logic [AW:0]            level,
   output logic [AW:0]            frames,
   output logic                   overflow
);

   logic [AW:0]            wr_ptr, rd_ptr;
   logic [AW:0]            wr_nxt, rd_nxt;
   logic [AW:0]            frames_q;
   logic [AXIS_WORD_W-1:0] rd_word;
   logic                   s_ready_q, ovf_q;
   logic                   full, empty;
   logic                   push, pop;
   logic                   push_last, pop_last;

   function automatic logic is_full(input logic [AW:0] w,
                                    input logic [AW:0] r);
      return (w[AW-1:0] == r[AW-1:0]) && (w[AW] != r[AW]);
   endfunction

   assign empty = (wr_ptr == rd_ptr);
   assign full  = is_full(wr_ptr, rd_ptr);

`ifdef AXIS_FIFO_PKT_MODE_EN
   // Hold output until a whole frame is stored; full forces
   // cut-through so oversized frames cannot deadlock.
   assign m_valid = !empty && ((frames_q != '0) || full);
`else
   assign m_valid = !empty;
`endif

   assign push      = s_valid && s_ready_q;
   assign pop       = m_valid && m_ready;
   assign push_last = push && s_last;
   assign pop_last  = pop && rd_word[AXIS_LAST_BIT];

   assign wr_nxt = wr_ptr + {{AW{1'b0}}, push};
   assign rd_nxt = rd_ptr + {{AW{1'b0}}, pop};

   axis_fifo_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr[AW-1:0]),
      .wdata ({s_last, s_data}),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rd_word)
   );

   // s_ready is registered from next-state pointers, so it is
   // exact one edge later and has no path from m_ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         s_ready_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         wr_ptr    <= wr_nxt;
         rd_ptr    <= rd_nxt;
         s_ready_q <= !is_full(wr_nxt, rd_nxt);
         if (s_valid && !s_ready_q) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frames_q <= '0;
      end else begin
         unique case ({push_last, pop_last})
            2'b10:   frames_q <= frames_q + 1'b1;
            2'b01:   frames_q <= frames_q - 1'b1;
            default: frames_q <= frames_q;
         endcase
      end
   end

   assign s_ready  = s_ready_q;
   assign m_data   = rd_word[AXIS_DATA_W-1:0];
   assign m_last   = rd_word[AXIS_LAST_BIT];
   assign level    = wr_ptr - rd_ptr;
   assign frames   = frames_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_axis_byte_fifo.sv
// Self-checking bench for axis_byte_fifo: queue-based reference
// model checked every cycle plus directed literal expectations.
module tb_axis_byte_fifo;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [7:0]    s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_last = 1'b0;
   logic          s_ready;
   logic [7:0]    m_data;
   logic          m_valid;
   logic          m_last;
   logic          m_ready = 1'b0;
   logic [AW:0]   level;
   logic [AW:0]   frames;
   logic          overflow;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   axis_byte_fifo #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_last   (m_last),
      .m_ready  (m_ready),
      .level    (level),
      .frames   (frames),
      .overflow (overflow)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Reference model: a queue of {last,data} words.
   logic [8:0] q[$];
   int         mdl_frames = 0;
   bit         mdl_srdy = 0;
   bit         mdl_ovf = 0;

   function automatic bit mdl_mv();
`ifdef AXIS_FIFO_PKT_MODE_EN
      return (q.size() > 0) && (mdl_frames > 0 || q.size() == DEPTH);
`else
      return q.size() > 0;
`endif
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            q.delete();
            mdl_frames = 0;
            mdl_srdy = 0;
            mdl_ovf = 0;
         end else begin
            bit         do_push, do_pop;
            logic [8:0] popped;
            do_push = s_valid && mdl_srdy;
            do_pop  = mdl_mv() && m_ready;
            popped  = '0;
            if (s_valid && !mdl_srdy) mdl_ovf = 1;
            if (do_pop) popped = q.pop_front();
            if (do_push) q.push_back({s_last, s_data});
            if (do_push && s_last) mdl_frames++;
            if (do_pop && popped[8]) mdl_frames--;
            mdl_srdy = q.size() < DEPTH;
         end
      end
   end

   // Compare DUT against model on every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("level", 32'(level), 32'(q.size()));
         chk("frames", 32'(frames), 32'(mdl_frames));
         chk("s_ready", 32'(s_ready), 32'(mdl_srdy));
         chk("overflow", 32'(overflow), 32'(mdl_ovf));
         chk("m_valid", 32'(m_valid), 32'(mdl_mv()));
         if (m_valid && mdl_mv()) begin
            chk("m_data", 32'(m_data), 32'(q[0][7:0]));
            chk("m_last", 32'(m_last), 32'(q[0][8]));
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic l);
      bit done;
      done = 0;
      s_valid = 1'b1;
      s_data = d;
      s_last = l;
      for (int t = 0; t < 60 && !done; t++) begin
         if (s_ready) done = 1;
         @(negedge clk);
      end
      if (!done) chk("send_timeout", 32'd1, 32'd0);
      s_valid = 1'b0;
      s_last = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 0;
      m_ready = 1'b1;
      for (int t = 0; t < 60 && !done; t++) begin
         @(negedge clk);
         if (!m_valid) done = 1;
      end
      if (!done) chk("drain_timeout", 32'd1, 32'd0);
      m_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rel_s_ready", 32'(s_ready), 32'd1);

      // Three beats, last on 0x33
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b1);
      chk("t1_level", 32'(level), 32'd3);
      chk("t1_frames", 32'(frames), 32'd1);
      chk("t1_d0", 32'(m_data), 32'h11);
      chk("t1_l0", 32'(m_last), 32'd0);
      m_ready = 1'b1;
      @(negedge clk);
      chk("t1_d1", 32'(m_data), 32'h22);
      chk("t1_l1", 32'(m_last), 32'd0);
      @(negedge clk);
      chk("t1_d2", 32'(m_data), 32'h33);
      chk("t1_l2", 32'(m_last), 32'd1);
      @(negedge clk);
      m_ready = 1'b0;
      chk("t1_level_end", 32'(level), 32'd0);
      chk("t1_frames_end", 32'(frames), 32'd0);

`ifndef AXIS_FIFO_PKT_MODE_EN
      // Fill to full, overflow attempt, single pop
      for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
      chk("t2_s_ready", 32'(s_ready), 32'd0);
      chk("t2_level", 32'(level), 32'd16);
      s_valid = 1'b1;
      s_data = 8'h10;
      repeat (2) @(negedge clk);
      chk("t2_ovf", 32'(overflow), 32'd1);
      chk("t2_level_hold", 32'(level), 32'd16);
      s_valid = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      chk("t2_s_ready_back", 32'(s_ready), 32'd1);
      chk("t2_level15", 32'(level), 32'd15);
      chk("t2_head", 32'(m_data), 32'h01);
      drain();

      // Full-rate streaming across 60 beats
      m_ready = 1'b1;
      s_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         s_data = 8'(i + 8'h40);
         @(negedge clk);
         chk("t3_m_valid", 32'(m_valid), 32'd1);
         chk("t3_data", 32'(m_data), 32'(8'(i + 8'h40)));
         chk("t3_level", 32'(level), 32'd1);
      end
      s_valid = 1'b0;
      @(negedge clk);
      m_ready = 1'b0;
      chk("t3_empty", 32'(level), 32'd0);
`endif

      // Simultaneous push and pop of last beats with frames=2
      send(8'h01, 1'b1);
      send(8'h02, 1'b1);
      chk("t4_frames2", 32'(frames), 32'd2);
      s_valid = 1'b1;
      s_data = 8'h03;
      s_last = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      s_last = 1'b0;
      m_ready = 1'b0;
      chk("t4_frames_keep", 32'(frames), 32'd2);
      chk("t4_level", 32'(level), 32'd2);
      chk("t4_head", 32'(m_data), 32'h02);
      drain();
      chk("t4_frames0", 32'(frames), 32'd0);

      // Reset mid-frame
      for (int i = 0; i < 5; i++) send(8'(8'h80 + i), 1'b0);
      chk("t5_level5", 32'(level), 32'd5);
      #2;
      reset = 1'b0;
      #1;
      chk("t5_level0", 32'(level), 32'd0);
      chk("t5_frames0", 32'(frames), 32'd0);
      chk("t5_m_valid0", 32'(m_valid), 32'd0);
      chk("t5_s_ready0", 32'(s_ready), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      chk("t5_s_ready_rel", 32'(s_ready), 32'd0);
      @(negedge clk);
      chk("t5_s_ready_up", 32'(s_ready), 32'd1);

`ifdef AXIS_FIFO_PKT_MODE_EN
      // Packet mode release and oversized frame
      send(8'hA0, 1'b0);
      chk("p_mv0", 32'(m_valid), 32'd0);
      send(8'hA1, 1'b0);
      chk("p_mv1", 32'(m_valid), 32'd0);
      send(8'hA2, 1'b1);
      chk("p_mv2", 32'(m_valid), 32'd1);
      chk("p_d0", 32'(m_data), 32'hA0);
      drain();
      chk("p_frames0", 32'(frames), 32'd0);
      for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
      chk("p_full_mv", 32'(m_valid), 32'd1);
      m_ready = 1'b1;
      for (int i = 16; i < 20; i++) send(8'(i), 1'b0);
      m_ready = 1'b0;
      do_reset();
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
